gestor_solicitudes: RTL



---
 rtl/gestor_solicitudes.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gestor_solicitudes.sv
// gestor_solicitudes: elevator request front end.
// Latches hall/cab button presses into the request vector s, clears the
// requests the car serves, and sequences the door (closed -> open -> closing).
// esperar tells the dispatch machine to hold the car while the door is busy.
module gestor_solicitudes #(
    parameter int OPEN_CYCLES  = 50,
    parameter int CLOSE_CYCLES = 10,
    parameter int CW           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] botones,
    input  logic [3:0] estado,
    output logic [9:0] s,
    output logic       esperar,
    output logic       puerta_abierta
);

    typedef enum logic [1:0] {
        CERRADA  = 2'd0,
        ABIERTA  = 2'd1,
        CERRANDO = 2'd2
    } door_t;

    localparam logic [CW-1:0] OPEN_LOAD  = CW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0] CLOSE_LOAD = CW'(CLOSE_CYCLES - 1);

    door_t          door_q, door_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [9:0]     s_q, s_d;
    logic           moving_prev_q;
    logic           puerta_abierta_q;

    logic [9:0]     floor_mask;
    logic [9:0]     stop_mask;
    logic [9:0]     floor_press;
    logic [9:0]     press_clr;
    logic [9:0]     clr;
    logic           stop_evt;
    logic           idle_req;

    // Request bits belonging to the current floor, and the subset a stop serves
    // (cab call plus the hall call in the car's direction of travel).
    always_comb begin
        floor_mask = 10'h000;
        stop_mask  = 10'h000;
        case (estado[1:0])
            2'd0: begin
                floor_mask = 10'h041;
                stop_mask  = 10'h041;
            end
            2'd1: begin
                floor_mask = 10'h086;
                stop_mask  = estado[2] ? 10'h084 : 10'h082;
            end
            2'd2: begin
                floor_mask = 10'h118;
                stop_mask  = estado[2] ? 10'h110 : 10'h108;
            end
            default: begin
                floor_mask = 10'h220;
                stop_mask  = 10'h220;
            end
        endcase
    end

    // A stop is the falling edge of the moving flag; a parked car with the door
    // closed answers any pending call at its own floor, whatever the direction.
    always_comb begin
        stop_evt    = moving_prev_q & ~estado[3];
        idle_req    = ~estado[3] & (door_q == CERRADA) & ~moving_prev_q
                      & (|(s_q & floor_mask));
        floor_press = botones & floor_mask;
    end

    // Door sequencing; a press at the current floor while the door is busy
    // keeps it open and is treated as already served.
    always_comb begin
        door_d    = door_q;
        cnt_d     = cnt_q;
        press_clr = 10'h000;
        case (door_q)
            CERRADA: begin
                if (stop_evt || idle_req) begin
                    door_d = ABIERTA;
                    cnt_d  = OPEN_LOAD;
                end
            end
            ABIERTA: begin
                if (|floor_press) begin
                    cnt_d     = OPEN_LOAD;
                    press_clr = floor_press;
                end else if (cnt_q == '0) begin
                    door_d = CERRANDO;
                    cnt_d  = CLOSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CERRANDO: begin
                if (|floor_press) begin
                    door_d    = ABIERTA;
                    cnt_d     = OPEN_LOAD;
                    press_clr = floor_press;
                end else if (cnt_q == '0) begin
                    door_d = CERRADA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                door_d = CERRADA;
                cnt_d  = '0;
            end
        endcase
    end

    // Served bits are cleared; clearing wins over a same-cycle press.
    always_comb begin
        clr = press_clr;
        if (stop_evt) begin
            clr = clr | stop_mask;
        end
        if (idle_req) begin
            clr = clr | floor_mask;
        end
        s_d = (s_q | botones) & ~clr;
    end

    // State registers; reset drops every request and closes the door at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q              <= 10'h000;
            door_q           <= CERRADA;
            cnt_q            <= '0;
            moving_prev_q    <= 1'b0;
            puerta_abierta_q <= 1'b0;
        end else begin
            s_q              <= s_d;
            door_q           <= door_d;
            cnt_q            <= cnt_d;
            moving_prev_q    <= estado[3];
            puerta_abierta_q <= (door_d == ABIERTA);
        end
    end

    // esperar is combinational so the dispatcher sees it in the very cycle
    // the car reports it has stopped.
    always_comb begin
        s              = s_q;
        puerta_abierta = puerta_abierta_q;
        esperar        = (door_q != CERRADA) | stop_evt | idle_req;
    end

endmodule
